// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if
//   Bus bundle between decode/writeback and the multi-port register file.
//   Parameters mirror the register file (XLEN, NREGS, NUM_RD); AW is derived.
//   Signals:
//     rd_addr   NUM_RD*AW    read addresses, port i at [i*AW +: AW]
//     rd_data   NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN]
//     we        1            write enable
//     wr_addr   AW           write address
//     wr_data   XLEN         write data
//     init_busy 1            clear sweep in progress
//     wr_drop   1            one-cycle pulse: requested write was discarded
//   master: requester side (decode/writeback); slave: register file side.
interface regfile_multiport_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned NUM_RD = 2
);
   localparam int unsigned AW = $clog2(NREGS);

   logic [NUM_RD*AW-1:0]   rd_addr;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic                   we;
   logic [AW-1:0]          wr_addr;
   logic [XLEN-1:0]        wr_data;
   logic                   init_busy;
   logic                   wr_drop;

   modport master (
      output rd_addr, we, wr_addr, wr_data,
      input  rd_data, init_busy, wr_drop
   );

   modport slave (
      input  rd_addr, we, wr_addr, wr_data,
      output rd_data, init_busy, wr_drop
   );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport
//   NREGS x XLEN register file with NUM_RD combinational read ports and one
//   synchronous write port. After srst a sequential sweep clears every
//   register (NREGS edges); reads return 0 and writes are dropped meanwhile.
//   Register 0 reads as zero and ignores writes when ZERO_REG=1.
//   Ports:
//     clk   rising-edge clock
//     srst  synchronous active-high reset
//     bus   regfile_multiport_if.slave (rd_addr/rd_data/we/wr_addr/wr_data/
//           init_busy/wr_drop)
//   Optional build macro RF_BYPASS_EN: write-first forwarding of wr_data to
//   read ports addressing the register being written in the same cycle.
//   Without it, a read in the write cycle returns the old value.
module regfile_multiport #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned NUM_RD   = 2,
   parameter bit          ZERO_REG = 1'b1
) (
   input logic                clk,
   input logic                srst,
   regfile_multiport_if.slave bus
);
   localparam int unsigned AW = $clog2(NREGS);
   localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
   localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

   typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     ctr_q, ctr_d;
   logic              wr_drop_q, wr_drop_d;
   logic [XLEN-1:0]   mem_q [NREGS];

   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [XLEN-1:0]   mem_wdata;
   logic              wr_ok;
   logic [NUM_RD*XLEN-1:0] rd_data_c;
   logic [AW-1:0]     ra;

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < NREGS_W;
   endfunction

   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   // A write that would architecturally land (ignores srst; srst is applied
   // where state is updated).
   assign wr_ok = bus.we && (state_q == READY) && in_range(bus.wr_addr)
                  && !is_zero_reg(bus.wr_addr);

   // State register
   always_ff @(posedge clk) begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      wr_drop_q <= wr_drop_d;
   end

   // Storage: no reset, contents defined by the sweep
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Next state, sweep and write-port control
   always_comb begin
      state_d   = state_q;
      ctr_d     = ctr_q;
      wr_drop_d = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.wr_data;
      if (srst) begin
         state_d = INIT;
         ctr_d   = '0;
      end else if (state_q == INIT) begin
         mem_we    = 1'b1;
         mem_waddr = ctr_q;
         mem_wdata = '0;
         if (ctr_q == LAST) begin
            state_d = READY;
         end else begin
            ctr_d = ctr_q + AW'(1);
         end
         wr_drop_d = bus.we;
      end else begin
         mem_we = wr_ok;
         // Writes to the hardwired zero register are legal, not drops
         wr_drop_d = bus.we && !in_range(bus.wr_addr);
      end
   end

   // Outputs
   always_comb begin
      rd_data_c = '0;
      ra        = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         ra = bus.rd_addr[i*AW +: AW];
         if ((state_q == READY) && in_range(ra) && !is_zero_reg(ra)) begin
`ifdef RF_BYPASS_EN
            if (wr_ok && (ra == bus.wr_addr)) begin
               rd_data_c[i*XLEN +: XLEN] = bus.wr_data;
            end else begin
               rd_data_c[i*XLEN +: XLEN] = mem_q[ra];
            end
`else
            rd_data_c[i*XLEN +: XLEN] = mem_q[ra];
`endif
         end
      end
   end

   assign bus.rd_data   = rd_data_c;
   assign bus.init_busy = (state_q == INIT);
   assign bus.wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Testbench for regfile_multiport. Two instances: A (NREGS=32, ZERO_REG=1)
// and B (NREGS=24, ZERO_REG=0), sharing clk and srst.
module tb_regfile_multiport;
   logic clk;
   logic srst;
   int   n_tests;
   int   n_fail;

`ifdef RF_BYPASS_EN
   localparam logic [31:0] EXP_RW = 32'h0000_005A;
`else
   localparam logic [31:0] EXP_RW = 32'h0000_00A5;
`endif

   regfile_multiport_if #(.XLEN(32), .NREGS(32), .NUM_RD(2)) bus_a ();
   regfile_multiport_if #(.XLEN(32), .NREGS(24), .NUM_RD(2)) bus_b ();

   regfile_multiport #(.XLEN(32), .NREGS(32), .NUM_RD(2), .ZERO_REG(1'b1)) dut_a (
      .clk (clk),
      .srst(srst),
      .bus (bus_a)
   );

   regfile_multiport #(.XLEN(32), .NREGS(24), .NUM_RD(2), .ZERO_REG(1'b0)) dut_b (
      .clk (clk),
      .srst(srst),
      .bus (bus_b)
   );

   logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
   assign a_rd0 = bus_a.rd_data[31:0];
   assign a_rd1 = bus_a.rd_data[63:32];
   assign b_rd0 = bus_b.rd_data[31:0];
   assign b_rd1 = bus_b.rd_data[63:32];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      srst = 1'b1;
      bus_a.we = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.rd_addr = {5'd6, 5'd5};
      bus_b.we = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.rd_addr = {5'd6, 5'd5};

      // Reset held for 3 edges
      repeat (3) step();
      check("rst_busy_a", bus_a.init_busy, 1);
      check("rst_busy_b", bus_b.init_busy, 1);
      check("rst_drop_a", bus_a.wr_drop, 0);
      check("rst_rd_a0", a_rd0, 0);

      // Sweep, with a dropped write to reg 3 on sweep cycle 10
      srst = 1'b0;
      for (int k = 0; k < 32; k++) begin
         bus_a.rd_addr = {5'(31 - k), 5'(k)};
         bus_a.we      = (k == 10);
         bus_a.wr_addr = 5'd3;
         bus_a.wr_data = 32'hFFFF_FFFF;
         #1;
         check("sweep_busy_a", bus_a.init_busy, 1);
         check("sweep_rd_a0", a_rd0, 0);
         check("sweep_rd_a1", a_rd1, 0);
         check("sweep_busy_b", bus_b.init_busy, (k < 24) ? 1 : 0);
         step();
         if (k == 10) check("init_drop_set", bus_a.wr_drop, 1);
         if (k == 11) check("init_drop_clr", bus_a.wr_drop, 0);
      end
      bus_a.we = 1'b0;
      #1;
      check("ready_a", bus_a.init_busy, 0);
      check("ready_b", bus_b.init_busy, 0);
      bus_a.rd_addr = {5'd4, 5'd3};
      #1;
      check("dropped_reg3", a_rd0, 0);

      // Basic write/read
      bus_a.we = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'hDEAD_BEEF;
      step();
      bus_a.we = 1'b0;
      bus_a.rd_addr = {5'd5, 5'd5};
      #1;
      check("wr_nodrop", bus_a.wr_drop, 0);
      check("rd5_p0", a_rd0, 32'hDEAD_BEEF);
      check("rd5_p1", a_rd1, 32'hDEAD_BEEF);
      bus_a.rd_addr = {5'd6, 5'd5};
      #1;
      check("rd6_zero", a_rd1, 0);

      // Register 0 writes: hardwired on A, ordinary on B
      bus_a.we = 1'b1; bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'h1234_5678;
      bus_a.rd_addr = {5'd0, 5'd0};
      bus_b.we = 1'b1; bus_b.wr_addr = 5'd0; bus_b.wr_data = 32'h1234_5678;
      bus_b.rd_addr = {5'd6, 5'd0};
      #1;
      check("zero_same_cycle", a_rd0, 0);
      step();
      bus_a.we = 1'b0; bus_b.we = 1'b0;
      #1;
      check("zero_rd_a", a_rd0, 0);
      check("zero_drop_a", bus_a.wr_drop, 0);
      check("r0_rd_b", b_rd0, 32'h1234_5678);
      check("r0_drop_b", bus_b.wr_drop, 0);

      // Out-of-range write on B (NREGS=24)
      bus_b.we = 1'b1; bus_b.wr_addr = 5'd30; bus_b.wr_data = 32'hCAFE_F00D;
      step();
      bus_b.we = 1'b0;
      bus_b.rd_addr = {5'd30, 5'd6};
      #1;
      check("oor_drop", bus_b.wr_drop, 1);
      check("oor_alias6", b_rd0, 0);
      check("oor_rd30", b_rd1, 0);
      bus_b.rd_addr = {5'd0, 5'd23};
      #1;
      check("oor_rd23", b_rd0, 0);
      check("oor_r0_kept", b_rd1, 32'h1234_5678);
      step();
      check("oor_drop_clr", bus_b.wr_drop, 0);

      // Same-cycle read/write of reg 7
      bus_a.we = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'h0000_00A5;
      step();
      bus_a.wr_data = 32'h0000_005A;
      bus_a.rd_addr = {5'd7, 5'd7};
      #1;
      check("rw_same_p0", a_rd0, EXP_RW);
      check("rw_same_p1", a_rd1, EXP_RW);
      step();
      bus_a.we = 1'b0;
      #1;
      check("rw_next_p0", a_rd0, 32'h0000_005A);
      check("rw_next_p1", a_rd1, 32'h0000_005A);

      // Reset mid-sweep
      srst = 1'b1;
      step();
      srst = 1'b0;
      bus_a.rd_addr = {5'd7, 5'd5};
      repeat (15) step();
      check("mid_busy", bus_a.init_busy, 1);
      srst = 1'b1;
      step();
      check("mid_rst_busy", bus_a.init_busy, 1);
      check("mid_rst_rd", a_rd1, 0);
      srst = 1'b0;
      for (int k = 0; k < 32; k++) begin
         check("resweep_busy", bus_a.init_busy, 1);
         step();
      end
      check("resweep_done", bus_a.init_busy, 0);
      check("resweep_done_b", bus_b.init_busy, 0);
      check("cleared_r5", a_rd0, 0);
      check("cleared_r7", a_rd1, 0);
      bus_b.rd_addr = {5'd0, 5'd0};
      #1;
      check("cleared_b_r0", b_rd0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
